// File: rtl/case_1_mul_share_arbiter.sv
// Round-robin front end that time-shares one external signed multiplier among
// NUM_REQ requesters, with one buffered response per requester.
module case_1_mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DIN0_WIDTH  = 4,
  parameter int DIN1_WIDTH  = 4,
  parameter int DOUT_WIDTH  = 4,
  parameter int MUL_LATENCY = 0
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_b,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [NUM_REQ*DOUT_WIDTH-1:0]    rsp_data,
  output logic [DIN0_WIDTH-1:0]            mul_din0,
  output logic [DIN1_WIDTH-1:0]            mul_din1,
  input  logic [DOUT_WIDTH-1:0]            mul_dout,
  output logic                             busy
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    pend_q, pend_d;
  logic [TAG_W-1:0]      ptr_q, ptr_d;
  logic [DIN0_WIDTH-1:0] din0_q, din0_d;
  logic [DIN1_WIDTH-1:0] din1_q, din1_d;
  logic [MUL_LATENCY:0]  vld_q, vld_d;
  logic [TAG_W-1:0]      tag_q [0:MUL_LATENCY];
  logic [TAG_W-1:0]      tag_d [0:MUL_LATENCY];
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DOUT_WIDTH-1:0] rsp_data_q [NUM_REQ];
  logic [DOUT_WIDTH-1:0] rsp_data_d [NUM_REQ];

  logic [DIN0_WIDTH-1:0] a_s [NUM_REQ];
  logic [DIN1_WIDTH-1:0] b_s [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  grant_any_s;
  logic [TAG_W-1:0]      grant_idx_s;
  logic [TAG_W-1:0]      idx_s;
  logic [NUM_REQ-1:0]    rsp_fire_s;
  logic                  cap_vld_s;
  logic [TAG_W-1:0]      cap_tag_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign a_s[g] = req_a[g*DIN0_WIDTH +: DIN0_WIDTH];
    assign b_s[g] = req_b[g*DIN1_WIDTH +: DIN1_WIDTH];
    assign rsp_data[g*DOUT_WIDTH +: DOUT_WIDTH] = rsp_data_q[g];
  end

  // Round-robin search starting at ptr; no grant while reset is asserted.
  always_comb begin
    eligible_s  = req_valid & ~pend_q;
    grant_s     = '0;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    idx_s       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = TAG_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_any_s && !ap_rst && eligible_s[idx_s]) begin
        grant_any_s        = 1'b1;
        grant_idx_s        = idx_s;
        grant_s[idx_s]     = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      ptr_d = (grant_idx_s == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Operand registers and the tag/valid line that tracks the multiplier pipeline.
  always_comb begin
    din0_d   = grant_any_s ? a_s[grant_idx_s] : '0;
    din1_d   = grant_any_s ? b_s[grant_idx_s] : '0;
    vld_d    = '0;
    vld_d[0] = grant_any_s;
    tag_d[0] = grant_idx_s;
    for (int k = 1; k <= MUL_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
  end

  assign cap_vld_s  = vld_q[MUL_LATENCY];
  assign cap_tag_s  = tag_q[MUL_LATENCY];
  assign rsp_fire_s = rsp_valid_q & rsp_ready;

  // Response buffers fill from the multiplier; pend drops the cycle after handshake.
  always_comb begin
    pend_d      = (pend_q & ~rsp_fire_s) | grant_s;
    rsp_valid_d = rsp_valid_q & ~rsp_fire_s;
    rsp_data_d  = rsp_data_q;
    if (cap_vld_s) begin
      rsp_valid_d[cap_tag_s] = 1'b1;
      rsp_data_d[cap_tag_s]  = mul_dout;
    end else begin
      rsp_data_d = rsp_data_q;
    end
  end

  // State registers with synchronous reset that also discards in-flight work.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      pend_q      <= '0;
      ptr_q       <= '0;
      din0_q      <= '0;
      din1_q      <= '0;
      vld_q       <= '0;
      rsp_valid_q <= '0;
      for (int k = 0; k <= MUL_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      din0_q      <= din0_d;
      din1_q      <= din1_d;
      vld_q       <= vld_d;
      rsp_valid_q <= rsp_valid_d;
      for (int k = 0; k <= MUL_LATENCY; k++) begin
        tag_q[k] <= tag_d[k];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= rsp_data_d[i];
      end
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_q;
  assign mul_din0  = din0_q;
  assign mul_din1  = din1_q;
  assign busy      = |pend_q;

endmodule

// File: tb/tb_case_1_mul_share_arbiter.sv
// Bench: two arbiter instances (multiplier latency 0 and 2) share one stimulus
// stream and are checked each cycle against a cycle-count reference model.
module tb_case_1_mul_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;

  logic [N-1:0]   req_ready_o [2];
  logic [N-1:0]   rsp_valid_o [2];
  logic [N*W-1:0] rsp_data_o  [2];
  logic [W-1:0]   din0_o [2];
  logic [W-1:0]   din1_o [2];
  logic [W-1:0]   dout_o [2];
  logic           busy_o [2];
  logic [W-1:0]   pipe1 = 4'h0;
  logic [W-1:0]   pipe2 = 4'h0;

  function automatic logic [3:0] prod4(input logic [3:0] a, input logic [3:0] b);
    int sa, sb;
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    return 4'(sa * sb);
  endfunction

  // Stand-in multipliers: combinational, and a two-stage pipeline.
  assign dout_o[0] = prod4(din0_o[0], din1_o[0]);
  always @(posedge clk) begin
    pipe1 <= prod4(din0_o[1], din1_o[1]);
    pipe2 <= pipe1;
  end
  assign dout_o[1] = pipe2;

  case_1_mul_share_arbiter #(.NUM_REQ(N), .DIN0_WIDTH(W), .DIN1_WIDTH(W), .DOUT_WIDTH(W), .MUL_LATENCY(0)) u_dut_l0 (
    .ap_clk(clk), .ap_rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[0]),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_o[0]), .mul_din0(din0_o[0]), .mul_din1(din1_o[0]),
    .mul_dout(dout_o[0]), .busy(busy_o[0]));

  case_1_mul_share_arbiter #(.NUM_REQ(N), .DIN0_WIDTH(W), .DIN1_WIDTH(W), .DOUT_WIDTH(W), .MUL_LATENCY(2)) u_dut_l2 (
    .ap_clk(clk), .ap_rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[1]),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_o[1]), .mul_din0(din0_o[1]), .mul_din1(din1_o[1]),
    .mul_dout(dout_o[1]), .busy(busy_o[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: per requester, a pending flag and the absolute cycle its answer shows up.
  logic [N-1:0] pend_m [2];
  int           arr_m  [2][N];
  logic [3:0]   next_m [2][N];
  logic [3:0]   shown_m[2][N];
  int           ptr_m  [2];
  logic [3:0]   exp_din0 [2];
  logic [3:0]   exp_din1 [2];
  int           lat_m  [2] = '{0, 2};

  logic [N-1:0]   obs_ready [2];
  logic [N-1:0]   obs_valid [2];
  logic [N*W-1:0] obs_data  [2];
  logic           obs_busy  [2];

  task automatic model_reset(input int d);
    pend_m[d] = '0;
    ptr_m[d]  = 0;
    exp_din0[d] = 4'h0;
    exp_din1[d] = 4'h0;
    for (int j = 0; j < N; j++) begin
      arr_m[d][j] = 0;
      next_m[d][j] = 4'h0;
      shown_m[d][j] = 4'h0;
    end
  endtask

  task automatic step();
    logic [N-1:0]   g, v;
    logic [N*W-1:0] dexp;
    int gi, i;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      g = '0; v = '0; dexp = '0; gi = -1;
      for (int k = 0; k < N; k++) begin
        i = (ptr_m[d] + k) % N;
        if (gi < 0 && !rst && req_valid[i] && !pend_m[d][i]) gi = i;
      end
      if (gi >= 0) g[gi] = 1'b1;
      for (int j = 0; j < N; j++) begin
        v[j] = pend_m[d][j] && (arr_m[d][j] <= cyc);
        dexp[j*W +: W] = shown_m[d][j];
      end
      obs_ready[d] = req_ready_o[d];
      obs_valid[d] = rsp_valid_o[d];
      obs_data[d]  = rsp_data_o[d];
      obs_busy[d]  = busy_o[d];
      total += 6;
      if (req_ready_o[d] !== g) begin
        bad++; $display("FAIL req_ready dut%0d cyc%0d: got %b want %b", d, cyc, req_ready_o[d], g);
      end
      if (rsp_valid_o[d] !== v) begin
        bad++; $display("FAIL rsp_valid dut%0d cyc%0d: got %b want %b", d, cyc, rsp_valid_o[d], v);
      end
      if (rsp_data_o[d] !== dexp) begin
        bad++; $display("FAIL rsp_data dut%0d cyc%0d: got %h want %h", d, cyc, rsp_data_o[d], dexp);
      end
      if (busy_o[d] !== (|pend_m[d])) begin
        bad++; $display("FAIL busy dut%0d cyc%0d: got %b want %b", d, cyc, busy_o[d], |pend_m[d]);
      end
      if (din0_o[d] !== exp_din0[d]) begin
        bad++; $display("FAIL mul_din0 dut%0d cyc%0d: got %h want %h", d, cyc, din0_o[d], exp_din0[d]);
      end
      if (din1_o[d] !== exp_din1[d]) begin
        bad++; $display("FAIL mul_din1 dut%0d cyc%0d: got %h want %h", d, cyc, din1_o[d], exp_din1[d]);
      end
      if (rst) begin
        model_reset(d);
      end else begin
        for (int j = 0; j < N; j++) begin
          if (v[j] && rsp_ready[j]) pend_m[d][j] = 1'b0;
          if (pend_m[d][j] && arr_m[d][j] == cyc + 1) shown_m[d][j] = next_m[d][j];
        end
        if (gi >= 0) begin
          pend_m[d][gi] = 1'b1;
          arr_m[d][gi]  = cyc + 2 + lat_m[d];
          next_m[d][gi] = prod4(req_a[gi*W +: W], req_b[gi*W +: W]);
          ptr_m[d]      = (gi + 1) % N;
          exp_din0[d]   = req_a[gi*W +: W];
          exp_din1[d]   = req_b[gi*W +: W];
        end else begin
          exp_din0[d] = 4'h0;
          exp_din1[d] = 4'h0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = '1;
    req_a = 16'($urandom); req_b = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    model_reset(0); model_reset(1);
    step(); step();
    total++;
    if (obs_ready[0] !== 4'b0000 || obs_valid[0] !== 4'b0000 || obs_busy[0] !== 1'b0) begin
      bad++; $display("FAIL reset_state: ready=%b valid=%b busy=%b want 0", obs_ready[0], obs_valid[0], obs_busy[0]);
    end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    rsp_ready = '1;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin req_valid = 4'b0001; set_op(0, 4'h3, 4'hE); end
      else req_valid = '0;
      step();
      if (c == 5) begin
        total++;
        if (obs_ready[0] !== 4'b0001) begin bad++; $display("FAIL single_accept: got %b want 0001", obs_ready[0]); end
      end
      if (c == 6) begin
        total++;
        if (obs_valid[0][0] !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", obs_valid[0][0]); end
      end
      if (c == 7) begin
        total++;
        if (obs_valid[0][0] !== 1'b1 || obs_data[0][3:0] !== 4'hA) begin
          bad++; $display("FAIL single_rsp: valid=%b data=%h want 1/a", obs_valid[0][0], obs_data[0][3:0]);
        end
      end
      if (c == 9) begin
        total++;
        if (obs_valid[1][0] !== 1'b1 || obs_data[1][3:0] !== 4'hA) begin
          bad++; $display("FAIL single_rsp_lat2: valid=%b data=%h want 1/a", obs_valid[1][0], obs_data[1][3:0]);
        end
      end
    end
  endtask

  task automatic test_all_four();
    logic [N-1:0] er, ev;
    do_reset();
    rsp_ready = '1; req_valid = '1;
    req_a = 16'($urandom); req_b = 16'($urandom);
    for (int k = 0; k < 7; k++) begin
      step();
      er = (k < 4) ? (4'b0001 << k) : 4'b0000;
      ev = (k >= 2 && k <= 5) ? (4'b0001 << (k - 2)) : 4'b0000;
      total += 2;
      if (obs_ready[0] !== er) begin bad++; $display("FAIL rr_ready k%0d: got %b want %b", k, obs_ready[0], er); end
      if (obs_valid[0] !== ev) begin bad++; $display("FAIL rr_valid k%0d: got %b want %b", k, obs_valid[0], ev); end
      req_valid = req_valid & ~obs_ready[0];
    end
    repeat (3) step();
  endtask

  task automatic test_trunc();
    logic [3:0] ta [4];
    logic [3:0] tb [4];
    logic [3:0] te [4];
    bit seen;
    ta = '{4'h7, 4'h8, 4'h8, 4'h0};
    tb = '{4'h7, 4'h8, 4'h1, 4'(($urandom))};
    te = '{4'h1, 4'h0, 4'h8, 4'h0};
    rsp_ready = '1;
    for (int t = 0; t < 4; t++) begin
      req_valid = 4'b0001; set_op(0, ta[t], tb[t]);
      step();
      req_valid = '0;
      seen = 0;
      for (int w = 0; w < 8 && !seen; w++) begin
        step();
        if (obs_valid[0][0] === 1'b1) begin
          seen = 1;
          total++;
          if (obs_data[0][3:0] !== te[t]) begin
            bad++; $display("FAIL trunc%0d: got %h want %h", t, obs_data[0][3:0], te[t]);
          end
        end
      end
      if (!seen) begin
        total++; bad++; $display("FAIL trunc%0d_timeout: got no rsp_valid want rsp_valid", t);
      end
      repeat (4) step();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] held;
    bit have;
    int others;
    have = 0; others = 0; held = 4'h0;
    rsp_ready = 4'b1101; req_valid = '1;
    req_a = 16'($urandom); req_b = 16'($urandom);
    for (int c = 0; c < 14; c++) begin
      step();
      if (have) begin
        total += 2;
        if (obs_ready[0][1] !== 1'b0) begin bad++; $display("FAIL bp_ready1 c%0d: got %b want 0", c, obs_ready[0][1]); end
        if (obs_data[0][7:4] !== held) begin bad++; $display("FAIL bp_hold c%0d: got %h want %h", c, obs_data[0][7:4], held); end
      end else if (obs_valid[0][1] === 1'b1) begin
        have = 1; held = obs_data[0][7:4];
      end
      for (int i = 0; i < N; i++) begin
        if (obs_ready[0][i]) begin
          set_op(i, 4'($urandom), 4'($urandom));
          if (i != 1) others++;
        end
      end
    end
    total++;
    if (others < 8) begin bad++; $display("FAIL bp_others: got %0d grants want >=8", others); end
    rsp_ready = '1; req_valid = '0;
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 0;
    rsp_ready = '1; req_valid = 4'b0100; set_op(2, 4'($urandom), 4'($urandom));
    for (int w = 0; w < 6 && !got; w++) begin
      step();
      if (obs_ready[0][2] === 1'b1) got = 1;
    end
    if (!got) begin total++; bad++; $display("FAIL rstmid_accept: got no grant want grant 2"); end
    req_valid = '0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if (obs_valid[0] !== 4'b0000 || obs_valid[1] !== 4'b0000 || obs_busy[0] !== 1'b0 || obs_busy[1] !== 1'b0) begin
        bad++; $display("FAIL rstmid_quiet c%0d: valid=%b/%b busy=%b/%b want 0", c, obs_valid[0], obs_valid[1], obs_busy[0], obs_busy[1]);
      end
    end
    req_valid = '1;
    step();
    total++;
    if (obs_ready[0] !== 4'b0001 || obs_ready[1] !== 4'b0001) begin
      bad++; $display("FAIL rstmid_first: got %b/%b want 0001", obs_ready[0], obs_ready[1]);
    end
    req_valid = '0;
    repeat (6) step();
  endtask

  task automatic test_lat2();
    logic [N-1:0]   ev;
    logic [N*W-1:0] m;
    logic [3:0]     ed;
    do_reset();
    rsp_ready = '1;
    set_op(3, 4'h5, 4'h3); set_op(0, 4'hC, 4'h3); set_op(1, 4'h2, 4'hF);
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: req_valid = 4'b1000;
        1: req_valid = 4'b0011;
        2: req_valid = 4'b0010;
        default: req_valid = 4'b0000;
      endcase
      step();
      if (k < 3) begin
        ev = (k == 0) ? 4'b1000 : ((k == 1) ? 4'b0001 : 4'b0010);
        total++;
        if (obs_ready[1] !== ev) begin bad++; $display("FAIL lat2_grant k%0d: got %b want %b", k, obs_ready[1], ev); end
      end else begin
        case (k)
          4: begin ev = 4'b1000; ed = 4'hF; end
          5: begin ev = 4'b0001; ed = 4'h4; end
          6: begin ev = 4'b0010; ed = 4'hE; end
          default: begin ev = 4'b0000; ed = 4'h0; end
        endcase
        m = obs_data[1];
        total++;
        if (obs_valid[1] !== ev) begin bad++; $display("FAIL lat2_valid k%0d: got %b want %b", k, obs_valid[1], ev); end
        for (int i = 0; i < N; i++) begin
          if (ev[i]) begin
            total++;
            if (m[i*W +: W] !== ed) begin bad++; $display("FAIL lat2_data k%0d: got %h want %h", k, m[i*W +: W], ed); end
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 4'($urandom);
      rsp_ready = 4'($urandom) | 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      step();
    end
    rst = 1'b0; req_valid = '0; rsp_ready = '1;
    repeat (8) step();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_all_four();
    test_trunc();
    test_backpressure();
    test_reset_mid();
    test_lat2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
